// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Holds the frame state encodings and the default oversampling count.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Ticks per bit minus one at 16x oversampling
    localparam int DEFAULT_SAMPLE_TIMES = 15;

endpackage

// File: rtl/uart_tx_hold.sv
// Transmit holding register with its tx_ready (holding empty) flag.
// A write is taken only while tx_ready is high; a load from the frame
// engine empties the register and wins over any write on the same edge.
module uart_tx_hold
    import uart_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    input  logic       load,
    output logic       tx_ready,
    output logic [7:0] hold_data
);

    // Capture accepted writes and free the register when the shifter takes it
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_ready  <= 1'b1;
            hold_data <= 8'h00;
        end else if (load) begin
            tx_ready  <= 1'b1;
        end else if (tx_wr && tx_ready) begin
            hold_data <= tx_data;
            tx_ready  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Each bit lasts SAMPLE_TIMES+1 tx_clk_en ticks.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even or odd, chosen by PARITY_ODD) after data bit 7.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int SAMPLE_TIMES = DEFAULT_SAMPLE_TIMES,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       tx_clk_en,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx
);

    localparam logic [3:0] LAST_SAMPLE = 4'(SAMPLE_TIMES);
    localparam logic       LAST_STOP   = 1'(STOP_BITS - 1);

    uart_state_t state;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_idx;
    logic        stop_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic        bit_end;
    logic        last_stop;
    logic        load;

`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`else
    logic        parity_cfg_unused;
    assign parity_cfg_unused = PARITY_ODD[0];
`endif

    assign hold_full = ~tx_ready;
    assign bit_end   = (sample_cnt == LAST_SAMPLE);
    assign last_stop = (stop_cnt == LAST_STOP);

    uart_tx_hold u_hold (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .load      (load),
        .tx_ready  (tx_ready),
        .hold_data (hold_data)
    );

    // Hand the holding byte to the shifter when idle or at the end of the last stop bit
    always_comb begin
        load = 1'b0;
        if (tx_clk_en && hold_full) begin
            if (state == IDLE)
                load = 1'b1;
            else if (state == STOP && bit_end && last_stop)
                load = 1'b1;
        end
    end

    // Frame sequencer; advances only on baud ticks and registers the line and busy flag
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
            stop_cnt   <= 1'b0;
            shift_reg  <= 8'h00;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (tx_clk_en) begin
            case (state)
                IDLE: begin
                    sample_cnt <= 4'd0;
                    if (load) begin
                        state     <= START;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                        shift_reg <= hold_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^hold_data) ^ PARITY_ODD[0];
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        sample_cnt <= 4'd0;
                        bit_idx    <= 3'd0;
                        state      <= DATA;
                        tx         <= shift_reg[0];
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        sample_cnt <= 4'd0;
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            tx       <= parity_bit;
`else
                            state    <= STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        sample_cnt <= 4'd0;
                        stop_cnt   <= 1'b0;
                        state      <= STOP;
                        tx         <= 1'b1;
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        sample_cnt <= 4'd0;
                        if (last_stop) begin
                            stop_cnt <= 1'b0;
                            if (load) begin
                                state     <= START;
                                tx        <= 1'b0;
                                shift_reg <= hold_data;
`ifdef UART_TX_PARITY_EN
                                parity_bit <= (^hold_data) ^ PARITY_ODD[0];
`endif
                            end else begin
                                state   <= IDLE;
                                tx      <= 1'b1;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sample_cnt <= 4'd0;
                    tx         <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed testbench for uart_transmitter (default parameters).
// Define UART_TX_PARITY_EN to also exercise the parity bit with an
// extra odd-parity instance.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BT = 16;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_clk_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx;

    int total = 0;
    int bad = 0;

    logic [7:0] pendingQ[$];
    int         forceTick = -1;
    logic [7:0] forceData = 8'h00;

    logic txLog    [0:1023];
    logic busyLog  [0:1023];
    logic readyLog [0:1023];
    logic txOddLog [0:1023];
    int   logN = 0;

    uart_transmitter dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .tx_clk_en (tx_clk_en),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .tx        (tx)
    );

`ifdef UART_TX_PARITY_EN
    logic txOddReady, txOddBusy, txOdd;
    uart_transmitter #(.PARITY_ODD(1)) dutOdd (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .tx_clk_en (tx_clk_en),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_ready  (txOddReady),
        .tx_busy   (txOddBusy),
        .tx        (txOdd)
    );
`endif

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock; writes last one cycle, queued writes go out once tx_ready is high
    task automatic stepClk();
        @(posedge sys_clk);
        #1;
        tx_wr = 1'b0;
        if (pendingQ.size() > 0 && tx_ready) begin
            tx_data = pendingQ.pop_front();
            tx_wr   = 1'b1;
        end
    endtask

    // Run n baud ticks (every 4 clocks, or random 1..20 gaps) and log the outputs
    task automatic applyStimulus(input int n, input bit irregular);
        int gap;
        logN = 0;
        for (int i = 0; i < n; i++) begin
            gap = irregular ? int'($urandom_range(1, 20)) : 4;
            repeat (gap - 1) stepClk();
            tx_clk_en = 1'b1;
            stepClk();
            tx_clk_en = 1'b0;
            txLog[logN]    = tx;
            busyLog[logN]  = tx_busy;
            readyLog[logN] = tx_ready;
`ifdef UART_TX_PARITY_EN
            txOddLog[logN] = txOdd;
`else
            txOddLog[logN] = 1'b1;
`endif
            logN++;
            if (i == forceTick) begin
                tx_data = forceData;
                tx_wr   = 1'b1;
            end
        end
    endtask

    function automatic int expBit(input logic [7:0] d, input int pos, input int odd);
        if (pos == 0) return 0;
        if (pos <= 8) return int'(d[pos-1]);
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return int'(^d) ^ odd;
`endif
        return 1;
    endfunction

    function automatic int findStart(input int from);
        for (int i = from; i < logN; i++)
            if (txLog[i] == 1'b0) return i;
        return -1;
    endfunction

    task automatic checkFrame(input string tag, input int s, input logic [7:0] d);
        int cnt;
        if (s < 0 || s + FB * BT > logN) begin
            checkOutput({tag, "_present"}, 0, 1);
            return;
        end
        for (int pos = 0; pos < FB; pos++) begin
            cnt = 0;
            for (int k = 0; k < BT; k++)
                if (int'(txLog[s + pos * BT + k]) == expBit(d, pos, 0)) cnt++;
            checkOutput($sformatf("%s_bit%0d", tag, pos), cnt, BT);
        end
    endtask

    function automatic int countOnes(input int from, input int len, input bit useBusy);
        int c = 0;
        for (int i = from; i < from + len && i < logN; i++)
            if (useBusy ? busyLog[i] : txLog[i]) c++;
        return c;
    endfunction

    initial begin
        int s;
        $display("[TB] start");

        // Reset state
        rst = 1'b1;
        repeat (2) stepClk();
        rst = 1'b0;
        checkOutput("rst_tx", int'(tx), 1);
        checkOutput("rst_busy", int'(tx_busy), 0);
        checkOutput("rst_ready", int'(tx_ready), 1);

        // Single 0x55 frame with a tick every 4 clocks
        pendingQ.push_back(8'h55);
        stepClk();
        stepClk();
        checkOutput("wr_ready_low", int'(tx_ready), 0);
        applyStimulus(FB * BT + 8, 1'b0);
        s = findStart(0);
        checkOutput("f55_start_tick", s, 0);
        checkOutput("f55_ready_back", int'(readyLog[0]), 1);
        checkFrame("f55", s, 8'h55);
        checkOutput("f55_busy_len", countOnes(0, FB * BT + 8, 1'b1), FB * BT);
        checkOutput("f55_busy_end", int'(busyLog[FB * BT]), 0);
        checkOutput("f55_idle_tx", int'(txLog[FB * BT]), 1);

        // Back-to-back 0xA5 then 0x3C, no idle gap
        pendingQ.push_back(8'hA5);
        pendingQ.push_back(8'h3C);
        stepClk();
        stepClk();
        applyStimulus(2 * FB * BT + 40, 1'b0);
        s = findStart(0);
        checkFrame("fA5", s, 8'hA5);
        checkFrame("f3C", s + FB * BT, 8'h3C);
        checkOutput("b2b_busy", countOnes(s, 2 * FB * BT, 1'b1), 2 * FB * BT);
        checkOutput("b2b_busy_end", int'(busyLog[s + 2 * FB * BT]), 0);
        checkOutput("b2b_queue", pendingQ.size(), 0);

        // Third write while holding is full must be dropped
        pendingQ.push_back(8'h11);
        pendingQ.push_back(8'h22);
        forceTick = 40;
        forceData = 8'h33;
        stepClk();
        stepClk();
        applyStimulus(2 * FB * BT + 40, 1'b0);
        forceTick = -1;
        s = findStart(0);
        checkFrame("f11", s, 8'h11);
        checkFrame("f22", s + FB * BT, 8'h22);
        checkOutput("drop_line_idle", countOnes(s + 2 * FB * BT, 40, 1'b0), 40);
        checkOutput("drop_busy_idle", countOnes(s + 2 * FB * BT, 40, 1'b1), 0);

        // Reset during data bit 3 of 0xFF, with tick and write on the reset edge
        pendingQ.push_back(8'hFF);
        stepClk();
        stepClk();
        applyStimulus(4 * BT + 8, 1'b0);
        checkOutput("ff_bit3_tx", int'(txLog[4 * BT + 7]), 1);
        checkOutput("ff_bit3_busy", int'(busyLog[4 * BT + 7]), 1);
        rst       = 1'b1;
        tx_clk_en = 1'b1;
        tx_wr     = 1'b1;
        tx_data   = 8'h00;
        @(posedge sys_clk);
        #1;
        rst       = 1'b0;
        tx_clk_en = 1'b0;
        tx_wr     = 1'b0;
        checkOutput("mid_rst_tx", int'(tx), 1);
        checkOutput("mid_rst_busy", int'(tx_busy), 0);
        checkOutput("mid_rst_ready", int'(tx_ready), 1);
        applyStimulus(200, 1'b0);
        checkOutput("post_rst_line", countOnes(0, 200, 1'b0), 200);
        checkOutput("post_rst_busy", countOnes(0, 200, 1'b1), 0);

`ifdef UART_TX_PARITY_EN
        // Parity bit of 0x07: even gives 1, odd gives 0
        pendingQ.push_back(8'h07);
        stepClk();
        stepClk();
        applyStimulus(FB * BT + 8, 1'b0);
        s = findStart(0);
        checkFrame("f07", s, 8'h07);
        if (s >= 0) begin
            int cnt = 0;
            for (int k = 0; k < BT; k++)
                if (txOddLog[s + 9 * BT + k] == 1'b0) cnt++;
            checkOutput("odd_parity_bit", cnt, BT);
        end else begin
            checkOutput("odd_parity_present", 0, 1);
        end
`endif

        // Irregular tick spacing still yields 16 ticks per bit
        pendingQ.push_back(8'h96);
        stepClk();
        stepClk();
        applyStimulus(FB * BT + 8, 1'b1);
        s = findStart(0);
        checkFrame("f96_irreg", s, 8'h96);
        if (s >= 0 && s + FB * BT < logN)
            checkOutput("f96_busy_end", int'(busyLog[s + FB * BT]), 0);
        else
            checkOutput("f96_end_present", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter SAMPLE_TIMES, default 15, meaning tx_clk_en ticks per bit minus 1 (16x tick).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits (legal values 1 or 2).
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0 (used only with UART_TX_PARITY_EN).
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port tx_clk_en, input, 1 bit: one-sys_clk-wide 16x baud tick.
REQ-007 SHALL have port tx_data, input, 8 bits: byte to send.
REQ-008 SHALL have port tx_wr, input, 1 bit: write strobe, sampled every sys_clk.
REQ-009 SHALL have port tx_ready, output, 1 bit: holding register empty, so a write is accepted.
REQ-010 SHALL have port tx_busy, output, 1 bit: a frame is on the line.
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high, registered.

Function
REQ-012 SHALL accept tx_wr only when tx_ready=1 at that edge; it latches tx_data into the holding register, and tx_ready falls the next cycle.
REQ-013 SHALL ignore tx_wr while tx_ready=0, leaving the holding contents unchanged and raising no error.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; any unused encoding SHALL go to IDLE.
REQ-015 SHALL advance the FSM and bit counters only on sys_clk edges where tx_clk_en=1; the holding and write logic runs every sys_clk.
REQ-016 SHALL, in IDLE with the holding register full on a tick, move to START, drive tx=0, copy the holding register to the shift register, and reassert tx_ready the next cycle.
REQ-017 SHALL make each bit (start, data, parity, each stop) last exactly SAMPLE_TIMES+1 ticks.
REQ-018 SHALL send data LSB first, bits 0..7, then go to PARITY (if compiled in) or STOP.
REQ-019 SHALL drive tx=1 for STOP_BITS bit periods in STOP.
REQ-020 SHALL, at the end of the last stop bit, go directly to START if the holding register is full (no idle gap) and otherwise go to IDLE.
REQ-021 SHALL hold tx_busy=1 from the START entry edge until the IDLE entry edge.
REQ-022 SHALL, when a write and a holding-to-shift transfer occur on the same edge, reject the write, because tx_ready was 0 at that edge.
REQ-023 SHALL use a sample counter of 4 bits and a bit index of 3 bits; wrap-around from 15 to 0 marks the bit boundary.
REQ-024 SHALL give 8N1 frame latency of 160 ticks from the START entry to the IDLE entry.

Reset
REQ-025 SHALL, in the cycle after rst=1, set tx=1, tx_busy=0, tx_ready=1, state IDLE, counters 0, holding register empty.
REQ-026 SHALL let rst override tx_clk_en and tx_wr on the same edge.
REQ-027 SHALL, on reset mid-frame, abandon the frame, return tx high the next cycle, and not resend the frame.

Configuration
REQ-028 SHALL, with UART_TX_PARITY_EN defined, insert one parity bit after bit 7: even parity = XOR of the data bits, odd parity = its inverse, selected by PARITY_ODD.
REQ-029 SHALL, without UART_TX_PARITY_EN, never enter PARITY, making the frame 8N1 or 8N2.

Structure
REQ-030 SHALL place the state encodings (IDLE/START/DATA/PARITY/STOP) and the default SAMPLE_TIMES in shared package uart_pkg, which the receiver also uses.
REQ-031 SHALL implement the holding register plus tx_ready logic as sub-module uart_tx_hold; everything else stays in uart_transmitter.

Verification
REQ-032 SHALL cover: tx_wr with 0x55 while idle, tick every 4 clocks -> tx reads 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks, tx_busy high for 160 ticks.
REQ-033 SHALL cover: write 0xA5, then write 0x3C as soon as tx_ready rises -> two contiguous frames with no idle gap, then tx_busy falls.
REQ-034 SHALL cover: three writes while busy and holding full -> only the first two bytes are transmitted, and the third is dropped.
REQ-035 SHALL cover: rst pulse during data bit 3 of 0xFF -> tx=1, tx_busy=0, tx_ready=1 the next cycle, and the line stays idle afterwards.
REQ-036 SHALL cover: with UART_TX_PARITY_EN and PARITY_ODD=0, send 0x07 -> parity bit 1 before stop; with PARITY_ODD=1 the parity bit is 0.
REQ-037 SHALL cover: irregular tx_clk_en gaps (1 to 20 clocks) -> bit durations still exactly 16 ticks each.
